// File: rtl/reg_bank_sb.sv
// NUM_REGS x DATA_W register file with R0 hardwired to zero, optional write-to-read bypass,
// a per-register pending scoreboard driving a RAW/WAW hazard stall, and a bypass-free debug port.
module reg_bank_sb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 1 << ADDR_W,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrReg,
    input  logic [ADDR_W-1:0]   rd,
    input  logic [DATA_W-1:0]   rdIn,
    input  logic [ADDR_W-1:0]   rs,
    input  logic [ADDR_W-1:0]   rt,
    input  logic                rsUse,
    input  logic                rtUse,
    output logic [DATA_W-1:0]   rsOut,
    output logic [DATA_W-1:0]   rtOut,
    input  logic                issueVld,
    input  logic [ADDR_W-1:0]   issueRd,
    output logic                stall,
    output logic [NUM_REGS-1:0] pendMask,
    input  logic [ADDR_W-1:0]   dbgAddr,
    output logic [DATA_W-1:0]   dbgOut
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                wr_en;
    logic                issue_en;

    assign wr_en = wrReg && (rd != '0);

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (addr == '0)
            return '0;
        if (BYPASS != 0 && wr_en && rd == addr)
            return rdIn;
        return regs[addr];
    endfunction

    // A retiring write on the same edge already satisfies the consumer when forwarding is on.
    function automatic logic busy(input logic [ADDR_W-1:0] addr);
        return (addr != '0) && pending[addr] && !(BYPASS != 0 && wr_en && rd == addr);
    endfunction

    always_comb begin
        rsOut  = read_port(rs);
        rtOut  = read_port(rt);
        dbgOut = (dbgAddr == '0) ? '0 : regs[dbgAddr];
        stall  = (rsUse && busy(rs)) || (rtUse && busy(rt)) || (issueVld && busy(issueRd));
    end

    assign issue_en = issueVld && !stall && (issueRd != '0);
    assign pendMask = pending;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            pending <= '0;
        end else begin
            if (wr_en) begin
                regs[rd]    <= rdIn;
                pending[rd] <= 1'b0;
            end
            if (issue_en)
                pending[issueRd] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: directed literal checks plus randomized traffic against an array model,
// covering BYPASS=1 and BYPASS=0 builds and a narrow 8x16 build.
module tb_reg_bank_sb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wrReg = 1'b0;
    logic [3:0]  rd = '0;
    logic [31:0] rdIn = '0;
    logic [3:0]  rs = '0;
    logic [3:0]  rt = '0;
    logic        rsUse = 1'b0;
    logic        rtUse = 1'b0;
    logic        issueVld = 1'b0;
    logic [3:0]  issueRd = '0;
    logic [3:0]  dbgAddr = '0;

    logic [31:0] rs_out [2];
    logic [31:0] rt_out [2];
    logic [31:0] dbg_out [2];
    logic        stall [2];
    logic [15:0] pend_mask [2];

    logic        s_wr = 1'b0;
    logic [2:0]  s_rd = '0;
    logic [15:0] s_rdIn = '0;
    logic [2:0]  s_rs = '0;
    logic [2:0]  s_rt = '0;
    logic        s_issue = 1'b0;
    logic [2:0]  s_issueRd = '0;
    logic [2:0]  s_dbg = '0;
    logic [15:0] s_rs_out, s_rt_out, s_dbg_out;
    logic        s_stall;
    logic [7:0]  s_pend;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    always #20 clk = ~clk;

    reg_bank_sb #(.BYPASS(1), .INIT_INDEX(1)) u_byp (
        .clk(clk), .reset(reset), .wrReg(wrReg), .rd(rd), .rdIn(rdIn), .rs(rs), .rt(rt),
        .rsUse(rsUse), .rtUse(rtUse), .rsOut(rs_out[0]), .rtOut(rt_out[0]),
        .issueVld(issueVld), .issueRd(issueRd), .stall(stall[0]), .pendMask(pend_mask[0]),
        .dbgAddr(dbgAddr), .dbgOut(dbg_out[0]));

    reg_bank_sb #(.BYPASS(0), .INIT_INDEX(1)) u_nobyp (
        .clk(clk), .reset(reset), .wrReg(wrReg), .rd(rd), .rdIn(rdIn), .rs(rs), .rt(rt),
        .rsUse(rsUse), .rtUse(rtUse), .rsOut(rs_out[1]), .rtOut(rt_out[1]),
        .issueVld(issueVld), .issueRd(issueRd), .stall(stall[1]), .pendMask(pend_mask[1]),
        .dbgAddr(dbgAddr), .dbgOut(dbg_out[1]));

    reg_bank_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1), .INIT_INDEX(0)) u_small (
        .clk(clk), .reset(reset), .wrReg(s_wr), .rd(s_rd), .rdIn(s_rdIn), .rs(s_rs), .rt(s_rt),
        .rsUse(1'b0), .rtUse(1'b0), .rsOut(s_rs_out), .rtOut(s_rt_out),
        .issueVld(s_issue), .issueRd(s_issueRd), .stall(s_stall), .pendMask(s_pend),
        .dbgAddr(s_dbg), .dbgOut(s_dbg_out));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: index 0 models the forwarding build, index 1 the non-forwarding build.
    logic [31:0] m_regs [2][16];
    logic [15:0] m_pend [2];

    function automatic bit fwd(input int k);
        return k == 0;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [3:0] a);
        if (a == 4'd0) return 32'd0;
        if (fwd(k) && wrReg && rd == a) return rdIn;
        return m_regs[k][a];
    endfunction

    function automatic bit m_busy(input int k, input logic [3:0] a);
        return (a != 4'd0) && m_pend[k][a] && !(fwd(k) && wrReg && rd == a);
    endfunction

    function automatic bit m_stall(input int k);
        return (rsUse && m_busy(k, rs)) || (rtUse && m_busy(k, rt)) || (issueVld && m_busy(k, issueRd));
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 16; i++) m_regs[k][i] = 32'(i);
                m_pend[k] = '0;
            end
        end else begin
            bit st [2];
            for (int k = 0; k < 2; k++) st[k] = m_stall(k);
            for (int k = 0; k < 2; k++) begin
                if (wrReg && rd != 4'd0) begin
                    m_regs[k][rd] = rdIn;
                    m_pend[k][rd] = 1'b0;
                end
                if (issueVld && !st[k] && issueRd != 4'd0) m_pend[k][issueRd] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model_rsOut[%0d]", k), 64'(rs_out[k]), 64'(m_read(k, rs)));
                check($sformatf("model_rtOut[%0d]", k), 64'(rt_out[k]), 64'(m_read(k, rt)));
                check($sformatf("model_dbgOut[%0d]", k), 64'(dbg_out[k]),
                      64'((dbgAddr == 4'd0) ? 32'd0 : m_regs[k][dbgAddr]));
                check($sformatf("model_stall[%0d]", k), 64'(stall[k]), 64'(m_stall(k)));
                check($sformatf("model_pendMask[%0d]", k), 64'(pend_mask[k]), 64'(m_pend[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b1;
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // Narrow build: zero reset contents, 8-bit mask, debug read of a write.
        for (int i = 0; i < 8; i++) begin
            s_dbg = 3'(i);
            #1 check($sformatf("small_reset_dbg%0d", i), 64'(s_dbg_out), 64'h0);
        end
        check("small_pend_reset", 64'(s_pend), 64'h0);
        s_wr = 1'b1; s_rd = 3'd7; s_rdIn = 16'hABCD;
        tick();
        s_wr = 1'b0; s_dbg = 3'd7;
        #1 check("small_dbg7", 64'(s_dbg_out), 64'hABCD);
        check("small_pend_after", 64'(s_pend), 64'h0);

        // Write to r5.
        wrReg = 1'b1; rd = 4'd5; rdIn = 32'hDEADBEEF; rs = 4'd5;
        #1 check("wr5_byp_same", 64'(rs_out[0]), 64'hDEADBEEF);
        check("wr5_nobyp_same", 64'(rs_out[1]), 64'd5);
        tick();
        wrReg = 1'b0;
        #1 check("wr5_byp_next", 64'(rs_out[0]), 64'hDEADBEEF);
        check("wr5_nobyp_next", 64'(rs_out[1]), 64'hDEADBEEF);

        // R0 discards writes.
        wrReg = 1'b1; rd = 4'd0; rdIn = 32'hFFFFFFFF; rs = 4'd0;
        #1 check("r0_same", 64'(rs_out[0]), 64'h0);
        tick();
        wrReg = 1'b0;
        #1 check("r0_next", 64'(rs_out[0]), 64'h0);
        check("r0_nobyp", 64'(rs_out[1]), 64'h0);
        check("r0_pend", 64'(pend_mask[0]), 64'h0);

        // Bypass r7.
        wrReg = 1'b1; rd = 4'd7; rdIn = 32'h1234; rs = 4'd7; rt = 4'd7;
        #1 check("byp_rs", 64'(rs_out[0]), 64'h1234);
        check("byp_rt", 64'(rt_out[0]), 64'h1234);
        check("nobyp_rs_old", 64'(rs_out[1]), 64'd7);
        check("nobyp_rt_old", 64'(rt_out[1]), 64'd7);
        tick();
        wrReg = 1'b0;
        #1 check("nobyp_rs_new", 64'(rs_out[1]), 64'h1234);
        check("nobyp_rt_new", 64'(rt_out[1]), 64'h1234);

        // RAW on r3.
        issueVld = 1'b1; issueRd = 4'd3;
        #1 check("raw_issue_nostall", 64'(stall[0]), 64'h0);
        tick();
        issueVld = 1'b0; rs = 4'd3; rsUse = 1'b0; rt = 4'd0;
        #1 check("raw_pend_byp", 64'(pend_mask[0]), 64'h0008);
        check("raw_pend_nobyp", 64'(pend_mask[1]), 64'h0008);
        check("raw_unused_nostall", 64'(stall[0]), 64'h0);
        rsUse = 1'b1;
        #1 check("raw_stall_byp", 64'(stall[0]), 64'h1);
        check("raw_stall_nobyp", 64'(stall[1]), 64'h1);
        tick();
        wrReg = 1'b1; rd = 4'd3; rdIn = 32'h55;
        #1 check("raw_wr_byp_free", 64'(stall[0]), 64'h0);
        check("raw_wr_nobyp_held", 64'(stall[1]), 64'h1);
        tick();
        wrReg = 1'b0;
        #1 check("raw_clr_byp", 64'(pend_mask[0]), 64'h0);
        check("raw_clr_nobyp", 64'(pend_mask[1]), 64'h0);
        check("raw_nobyp_free", 64'(stall[1]), 64'h0);
        rsUse = 1'b0;

        // WAW on r4, then same-edge set and clear.
        issueVld = 1'b1; issueRd = 4'd4;
        tick();
        #1 check("waw_pend", 64'(pend_mask[0]), 64'h0010);
        check("waw_stall_byp", 64'(stall[0]), 64'h1);
        check("waw_stall_nobyp", 64'(stall[1]), 64'h1);
        tick();
        check("waw_pend_hold", 64'(pend_mask[0]), 64'h0010);
        wrReg = 1'b1; rd = 4'd4; rdIn = 32'h66;
        #1 check("setclr_stall_byp", 64'(stall[0]), 64'h0);
        check("setclr_stall_nobyp", 64'(stall[1]), 64'h1);
        tick();
        wrReg = 1'b0; issueVld = 1'b0;
        #1 check("setclr_pend_byp", 64'(pend_mask[0]), 64'h0010);
        check("setclr_pend_nobyp", 64'(pend_mask[1]), 64'h0);

        // Mid-cycle asynchronous reset.
        #2 reset = 1'b1;
        for (int i = 1; i < 16; i++) begin
            rs = 4'(i);
            #1 check($sformatf("rst_rs%0d_byp", i), 64'(rs_out[0]), 64'(i));
            check($sformatf("rst_rs%0d_nobyp", i), 64'(rs_out[1]), 64'(i));
        end
        rs = 4'd0; rsUse = 1'b1; rt = 4'd4; rtUse = 1'b1;
        #1 check("rst_rs0", 64'(rs_out[0]), 64'h0);
        check("rst_pend", 64'(pend_mask[0]), 64'h0);
        check("rst_stall", 64'(stall[0]), 64'h0);
        rsUse = 1'b0; rtUse = 1'b0;
        wrReg = 1'b1; rd = 4'd9; rdIn = 32'hCAFE; rs = 4'd9; dbgAddr = 4'd9;
        #1 check("rst_byp_active", 64'(rs_out[0]), 64'hCAFE);
        check("rst_nobyp_old", 64'(rs_out[1]), 64'd9);
        check("rst_dbg_nobypass", 64'(dbg_out[0]), 64'd9);
        tick();
        check("rst_write_ignored", 64'(dbg_out[0]), 64'd9);
        reset = 1'b0; wrReg = 1'b0;
        tick();
        for (int i = 1; i < 16; i++) begin
            rs = 4'(i);
            #1 check($sformatf("post_rst_rs%0d", i), 64'(rs_out[0]), 64'(i));
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            wrReg    = ($urandom_range(0, 99) < 40);
            rd       = 4'($urandom);
            rdIn     = $urandom;
            rs       = 4'($urandom);
            rt       = 4'($urandom);
            rsUse    = 1'($urandom);
            rtUse    = 1'($urandom);
            issueVld = ($urandom_range(0, 99) < 50);
            issueRd  = 4'($urandom);
            dbgAddr  = 4'($urandom);
            reset    = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; wrReg = 1'b0; issueVld = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
